// File: rtl/avalon_burst_responder.sv
// -----------------------------------------------------------------------------
// avalon_burst_responder
//
// Avalon-MM burst slave backed by on-chip RAM. Stands in for the SDRAM
// controller so the test master's burst sequencing can be exercised without
// external memory. Reads are pipelined (READ_LATENCY cycles from acceptance to
// the first readdatavalid), protocol errors raise a sticky flag, and accepted
// write beats / delivered read beats are counted.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   address, burstcount command word address / beats, sampled on acceptance
//   write, read         requests (write is also the per-beat valid)
//   writedata, byteenable write beat data and per-byte enable
//   waitrequest         slave stall
//   readdata, readdatavalid read beat data / valid
//   busy                FSM is not IDLE
//   err                 sticky protocol error (illegal burstcount, or
//                       read+write together during a write burst)
//   beats_wr, beats_rd  wrapping beat counters
//
// Optional feature macro: BACKPRESSURE_EN
//   Inserts one waitrequest cycle before every write beat whose index[1:0]==3
//   and one readdatavalid gap after every 4th delivered read beat.
// -----------------------------------------------------------------------------
module avalon_burst_responder #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 22,
  parameter int MEM_AW       = 10,
  parameter int BURST_W      = 9,
  parameter int MAX_BURST    = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic [BURST_W-1:0]    burstcount,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W/8-1:0]   byteenable,
  output logic                  waitrequest,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           beats_wr,
  output logic [15:0]           beats_rd
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [31:0] LP_MAX_BURST_32 = MAX_BURST;
  localparam logic [BURST_W:0] LP_MAX_BURST = LP_MAX_BURST_32[BURST_W:0];

  typedef enum logic [1:0] {S_IDLE, S_WR_BURST, S_RD_BURST} state_t;

  state_t                  r_state, w_state_nxt;
  logic [MEM_AW-1:0]       r_base;
  logic [BURST_W-1:0]      r_bc;
  logic [BURST_W-1:0]      r_idx;     // index of the next write beat
  logic [BURST_W-1:0]      r_issue;   // read addresses issued so far
  logic [BURST_W-1:0]      r_deliv;   // read beats delivered so far
  logic                    r_err;
  logic [15:0]             r_beats_wr, r_beats_rd;
  logic                    r_rd_gap;
  logic [READ_LATENCY-1:0] r_vpipe;
  logic [DATA_W-1:0]       r_mem   [2**MEM_AW];
  logic [DATA_W-1:0]       r_dpipe [READ_LATENCY];

  logic                    w_bc_bad;
  logic [BURST_W-1:0]      w_bc_eff;
  logic                    w_waitreq, w_bp_stall, w_wr_acc, w_rd_acc;
  logic                    w_issue, w_rd_gap_set, w_rd_last, w_rdv;
  logic [MEM_AW-1:0]       w_wr_addr, w_rd_addr;
  logic                    w_unused_addr;

  // Upper address bits alias onto the implemented RAM.
  assign w_unused_addr = ^address[ADDR_W-1:MEM_AW];

  // Illegal burst lengths are served as a single beat.
  assign w_bc_bad = (burstcount == '0) || ({1'b0, burstcount} > LP_MAX_BURST);
  assign w_bc_eff = w_bc_bad ? BURST_W'(1) : burstcount;

`ifdef BACKPRESSURE_EN
  logic r_bp_done;  // the stall for the pending index-3 beat has been served

  assign w_bp_stall   = (r_state == S_WR_BURST) && (r_idx[1:0] == 2'b11) && !r_bp_done;
  assign w_rd_gap_set = w_issue && (r_issue[1:0] == 2'b11);

  always_ff @(posedge clk) begin
    if (reset)           r_bp_done <= 1'b0;
    else if (w_wr_acc)   r_bp_done <= 1'b0;
    else if (w_bp_stall) r_bp_done <= 1'b1;
  end
`else
  assign w_bp_stall   = 1'b0;
  assign w_rd_gap_set = 1'b0;
`endif

  // NOTE: every signal driven from always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_waitreq = 1'b0;
    unique case (r_state)
      // A lone read during a write burst is held off until the burst ends.
      S_WR_BURST: w_waitreq = (read && !write) || w_bp_stall;
      S_RD_BURST: w_waitreq = 1'b1;
      default:    w_waitreq = 1'b0;
    endcase
    if (reset) w_waitreq = 1'b1;
  end

  assign w_wr_acc  = write && !w_waitreq;
  assign w_rd_acc  = read && !write && !w_waitreq && (r_state == S_IDLE);
  assign w_issue   = (r_state == S_RD_BURST) && (r_issue != r_bc) && !r_rd_gap;
  assign w_rdv     = r_vpipe[READ_LATENCY-1];
  assign w_rd_last = w_rdv && (r_deliv == r_bc - BURST_W'(1));

  assign w_wr_addr = (r_state == S_IDLE) ? address[MEM_AW-1:0]
                                         : r_base + MEM_AW'(r_idx);
  assign w_rd_addr = r_base + MEM_AW'(r_issue);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_acc) begin
          if (w_bc_eff != BURST_W'(1)) w_state_nxt = S_WR_BURST;
        end else if (w_rd_acc) begin
          w_state_nxt = S_RD_BURST;
        end
      end
      S_WR_BURST: if (w_wr_acc && (r_idx == r_bc - BURST_W'(1))) w_state_nxt = S_IDLE;
      S_RD_BURST: if (w_rd_last) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_bc       <= '0;
      r_idx      <= '0;
      r_issue    <= '0;
      r_deliv    <= '0;
      r_err      <= 1'b0;
      r_beats_wr <= '0;
      r_beats_rd <= '0;
      r_rd_gap   <= 1'b0;
      r_vpipe    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_wr_acc && (r_state == S_IDLE)) begin
        r_base <= address[MEM_AW-1:0];
        r_bc   <= w_bc_eff;
        r_idx  <= BURST_W'(1);
      end else if (w_wr_acc) begin
        r_idx  <= r_idx + BURST_W'(1);
      end

      if (w_rd_acc) begin
        r_base  <= address[MEM_AW-1:0];
        r_bc    <= w_bc_eff;
        r_issue <= '0;
        r_deliv <= '0;
      end else begin
        if (w_issue) r_issue <= r_issue + BURST_W'(1);
        if (w_rdv)   r_deliv <= r_deliv + BURST_W'(1);
      end

      r_rd_gap   <= w_rd_gap_set;
      r_vpipe[0] <= w_issue;
      for (int i = 1; i < READ_LATENCY; i++) r_vpipe[i] <= r_vpipe[i-1];

      if (((w_wr_acc || w_rd_acc) && (r_state == S_IDLE) && w_bc_bad) ||
          (w_wr_acc && read && (r_state == S_WR_BURST)))
        r_err <= 1'b1;

      if (w_wr_acc) r_beats_wr <= r_beats_wr + 16'd1;
      if (w_rdv)    r_beats_rd <= r_beats_rd + 16'd1;
    end
  end

  // NOTE: the RAM and its read-data pipeline carry no reset so they map onto
  // block RAM; readdata is forced to zero outside valid beats instead.
  // Separate write and registered read give old data on same-address collision.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int b = 0; b < BE_W; b++)
        if (byteenable[b]) r_mem[w_wr_addr][8*b +: 8] <= writedata[8*b +: 8];
    end
    r_dpipe[0] <= r_mem[w_rd_addr];
    for (int i = 1; i < READ_LATENCY; i++) r_dpipe[i] <= r_dpipe[i-1];
  end

  assign waitrequest   = w_waitreq;
  assign readdatavalid = w_rdv;
  assign readdata      = w_rdv ? r_dpipe[READ_LATENCY-1] : '0;
  assign busy          = (r_state != S_IDLE);
  assign err           = r_err;
  assign beats_wr      = r_beats_wr;
  assign beats_rd      = r_beats_rd;

endmodule

// File: tb/tb_avalon_burst_responder.sv
// -----------------------------------------------------------------------------
// tb_avalon_burst_responder
//
// Self-checking bench for avalon_burst_responder with default parameters.
// Single-beat accesses come from a table of {op, address, data, byteenable,
// expected}; long bursts, wrap-around, error cases and reset mid-read are
// hand-written sequences. Read timing expectations follow BACKPRESSURE_EN.
// -----------------------------------------------------------------------------
module tb_avalon_burst_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [21:0] address = '0;
  logic [8:0]  burstcount = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [15:0] writedata = '0;
  logic [1:0]  byteenable = '0;
  logic        waitrequest;
  logic [15:0] readdata;
  logic        readdatavalid;
  logic        busy;
  logic        err;
  logic [15:0] beats_wr;
  logic [15:0] beats_rd;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] got_data [$];
  int          got_cyc  [$];

  typedef struct {
    bit          is_wr;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [11];

  avalon_burst_responder dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .burstcount    (burstcount),
    .write         (write),
    .read          (read),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .busy          (busy),
    .err           (err),
    .beats_wr      (beats_wr),
    .beats_rd      (beats_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle (counted from the acceptance edge) at which read beat i is valid.
  function automatic int exp_cyc(input int i);
`ifdef BACKPRESSURE_EN
    return 2 + i + i / 4;
`else
    return 2 + i;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; write = 1'b0; read = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_waitreq", 32'(waitrequest), 1);
    check("rst_rdv", 32'(readdatavalid), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
  endtask

  // Drive nbeats write beats; beat rw_beat also raises read.
  task automatic wr_burst(input logic [21:0] addr, input logic [8:0] bc, input int nbeats,
                          input logic [15:0] d0, input logic [1:0] be, input int rw_beat);
    int stalls;
    int exp_st;
    @(negedge clk);
    address = addr; burstcount = bc; byteenable = be;
    for (int i = 0; i < nbeats; i++) begin
      write = 1'b1; writedata = d0 + 16'(i); read = (i == rw_beat);
      #1;
      stalls = 0;
      while (waitrequest && stalls < 20) begin
        stalls++;
        @(negedge clk); #1;
      end
`ifdef BACKPRESSURE_EN
      exp_st = (i % 4 == 3) ? 1 : 0;
`else
      exp_st = 0;
`endif
      check($sformatf("wr_%0h_stall%0d", addr, i), stalls, exp_st);
      @(posedge clk); #1;
    end
    write = 1'b0; read = 1'b0;
  endtask

  // Issue one read command and collect up to nbeats valid beats.
  task automatic rd_burst(input logic [21:0] addr, input logic [8:0] bc, input int nbeats);
    int waits;
    got_data.delete(); got_cyc.delete();
    @(negedge clk);
    address = addr; burstcount = bc; read = 1'b1;
    #1;
    waits = 0;
    while (waitrequest && waits < 20) begin
      waits++;
      @(negedge clk); #1;
    end
    check($sformatf("rd_%0h_accept_wait", addr), waits, 0);
    @(posedge clk); #1;
    read = 1'b0;
    for (int c = 0; c < 2 * nbeats + 40 && got_data.size() < nbeats; c++) begin
      @(negedge clk);
      if (readdatavalid) begin
        got_data.push_back(readdata);
        got_cyc.push_back(c);
      end
    end
    @(negedge clk);
    check($sformatf("rd_%0h_no_extra", addr), 32'(readdatavalid), 0);
    check($sformatf("rd_%0h_idle_after", addr), 32'(busy), 0);
  endtask

  task automatic chk_burst(input string name, input int nbeats, input logic [15:0] first);
    check({name, "_beats"}, got_data.size(), nbeats);
    foreach (got_data[i]) begin
      check($sformatf("%s_d%0d", name, i), 32'(got_data[i]), 32'(first + 16'(i)));
      check($sformatf("%s_t%0d", name, i), got_cyc[i], exp_cyc(i));
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 22'h000010, 16'h1234, 2'b11, 16'h0000};
    vecs[1]  = '{1'b1, 22'h000010, 16'hFFFF, 2'b01, 16'h0000};
    vecs[2]  = '{1'b0, 22'h000010, 16'h0000, 2'b00, 16'h12FF};
    vecs[3]  = '{1'b1, 22'h000011, 16'h0000, 2'b11, 16'h0000};
    vecs[4]  = '{1'b1, 22'h000011, 16'hABCD, 2'b10, 16'h0000};
    vecs[5]  = '{1'b0, 22'h000011, 16'h0000, 2'b00, 16'hAB00};
    vecs[6]  = '{1'b1, 22'h000420, 16'h7777, 2'b11, 16'h0000};
    vecs[7]  = '{1'b0, 22'h000020, 16'h0000, 2'b00, 16'h7777};
    vecs[8]  = '{1'b1, 22'h3FFFFF, 16'hC0DE, 2'b11, 16'h0000};
    vecs[9]  = '{1'b0, 22'h0003FF, 16'h0000, 2'b00, 16'hC0DE};
    vecs[10] = '{1'b0, 22'h000005, 16'h0000, 2'b00, 16'hA5A5};

    // Reset state
    do_reset();
    @(negedge clk);
    check("idle_waitreq", 32'(waitrequest), 0);
    check("idle_readdata", 32'(readdata), 0);
    check("idle_err", 32'(err), 0);
    check("idle_beats_wr", 32'(beats_wr), 0);
    check("idle_beats_rd", 32'(beats_rd), 0);

    // Single write then single read: latency and counters
    wr_burst(22'h000005, 9'd1, 1, 16'hA5A5, 2'b11, -1);
    rd_burst(22'h000005, 9'd1, 1);
    chk_burst("single", 1, 16'hA5A5);
    check("single_beats_wr", 32'(beats_wr), 1);
    check("single_beats_rd", 32'(beats_rd), 1);
    check("single_err", 32'(err), 0);

    // Table of single-beat accesses (byte enables, address aliasing)
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].is_wr) begin
        wr_burst(vecs[v].addr, 9'd1, 1, vecs[v].data, vecs[v].be, -1);
        @(negedge clk);
        check($sformatf("vec%0d_busy", v), 32'(busy), 0);
      end else begin
        rd_burst(vecs[v].addr, 9'd1, 1);
        chk_burst($sformatf("vec%0d", v), 1, vecs[v].exp);
      end
    end

    // Maximum-length bursts from a fresh reset
    do_reset();
    wr_burst(22'h000000, 9'd256, 256, 16'h0000, 2'b11, -1);
    rd_burst(22'h000000, 9'd256, 256);
    chk_burst("max", 256, 16'h0000);
    check("max_beats_wr", 32'(beats_wr), 256);
    check("max_beats_rd", 32'(beats_rd), 256);
    check("max_err", 32'(err), 0);

    // 8-beat bursts (stall / gap pattern depends on BACKPRESSURE_EN)
    wr_burst(22'h000100, 9'd8, 8, 16'h0100, 2'b11, -1);
    rd_burst(22'h000100, 9'd8, 8);
    chk_burst("eight", 8, 16'h0100);

    // Wrap at the top of the RAM
    wr_burst(22'h0003FC, 9'd8, 8, 16'h0001, 2'b11, -1);
    rd_burst(22'h000000, 9'd4, 4);
    chk_burst("wrap_lo", 4, 16'h0005);
    rd_burst(22'h0003FE, 9'd4, 4);
    chk_burst("wrap_rd", 4, 16'h0003);

    // Reset in the middle of a read burst
    @(negedge clk);
    address = 22'h000100; burstcount = 9'd8; read = 1'b1;
    #1;
    check("midrst_accept", 32'(waitrequest), 0);
    @(posedge clk); #1;
    read = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_rdv_before", 32'(readdatavalid), 1);
    check("midrst_busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rdv_after", 32'(readdatavalid), 0);
    check("midrst_busy_after", 32'(busy), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_rdv_quiet", 32'(readdatavalid), 0);
    check("midrst_beats_rd", 32'(beats_rd), 0);
    rd_burst(22'h000000, 9'd1, 1);
    chk_burst("ram_kept", 1, 16'h0005);

    // burstcount = 0 on a write: one beat, sticky err
    do_reset();
    wr_burst(22'h000040, 9'd0, 1, 16'h0BAD, 2'b11, -1);
    check("bc0_err", 32'(err), 1);
    check("bc0_busy", 32'(busy), 0);
    rd_burst(22'h000040, 9'd1, 1);
    chk_burst("bc0", 1, 16'h0BAD);
    check("bc0_err_sticky", 32'(err), 1);
    check("bc0_beats_wr", 32'(beats_wr), 1);

    // burstcount > MAX_BURST on a read: one beat, err
    do_reset();
    check("err_cleared", 32'(err), 0);
    rd_burst(22'h000100, 9'd300, 1);
    chk_burst("bc300", 1, 16'h0100);
    check("bc300_err", 32'(err), 1);

    // read together with write inside a write burst
    do_reset();
    wr_burst(22'h000050, 9'd2, 2, 16'h5000, 2'b11, 1);
    check("rw_err", 32'(err), 1);
    check("rw_beats_wr", 32'(beats_wr), 2);
    rd_burst(22'h000050, 9'd2, 2);
    chk_burst("rw", 2, 16'h5000);
    repeat (3) @(negedge clk);
    check("rw_err_sticky", 32'(err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_burst_responder.md
Name: avalon_burst_responder

Overview:
Avalon-MM burst slave that terminates the user-side burst interface of the SDRAM test master with on-chip RAM. It accepts write and read bursts with waitrequest/readdatavalid timing. It stands in for the SDRAM controller in simulation and on-chip bring-up, so the master's burst sequencing can be checked without external SDRAM. Pipelined reads, sticky protocol-error flag, observable beat counters.

Parameters:
DATA_W, 16, data bus width (multiple of 8)
ADDR_W, 22, master address width; word address
MEM_AW, 10, implemented RAM depth 2**MEM_AW words; upper address bits ignored
BURST_W, 9, burstcount width
MAX_BURST, 256, largest legal burst
READ_LATENCY, 2, cycles from read acceptance to first readdatavalid (min 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
address  in  ADDR_W  word address, sampled on command acceptance only
burstcount  in  BURST_W  beats, sampled on command acceptance only
write  in  1  write request / beat valid
read  in  1  read request
writedata  in  DATA_W  write beat data
byteenable  in  DATA_W/8  per-byte write enable
waitrequest  out  1  slave stall
readdata  out  DATA_W  read beat data
readdatavalid  out  1  read beat valid
busy  out  1  high in any state other than IDLE
err  out  1  sticky protocol error
beats_wr  out  16  count of accepted write beats, wraps
beats_rd  out  16  count of delivered read beats, wraps

Behaviour:
- Reset values: waitrequest=1 for the reset cycle, then 0 in IDLE. readdatavalid=0, readdata=0, busy=0, err=0, beats_wr=0, beats_rd=0, FSM=IDLE. RAM contents are not cleared.
- A beat or command is accepted on a clock edge where (write|read) && !waitrequest.
- States:
  - IDLE: waitrequest=0. write has priority. If write: latch address[MEM_AW-1:0] and burstcount, store beat 0, remaining=bc-1; go to WR_BURST if remaining>0, else stay in IDLE. Else if read: latch address and burstcount; waitrequest=1 from the next cycle; go to RD_BURST.
  - WR_BURST: waitrequest=0. Each cycle with write=1 stores writedata at the base address plus the beat index, masked by byteenable. Cycles with write=0 are idle gaps, allowed, no state change. Return to IDLE after the last beat. A read asserted here is stalled.
  - RD_BURST: waitrequest=1. Addresses are issued one per cycle into a READ_LATENCY-deep pipeline. readdatavalid is high for exactly bc consecutive cycles, the first one READ_LATENCY cycles after acceptance. Return to IDLE on the cycle the last beat is valid; a new command can be accepted on the following cycle.
- Address arithmetic is modulo 2**MEM_AW; bursts wrap at the top of the RAM.
- burstcount=0 or >MAX_BURST: treated as 1 beat; err set.
- write and read both high in WR_BURST: err set; the write beat is still accepted.
- beats_wr increments per accepted write beat. beats_rd increments per readdatavalid cycle.
- Reset mid-burst: abort immediately; the pipeline is flushed; readdatavalid=0 on the next cycle; RAM keeps the beats already written.
- RAM is inferred as a simple dual-port with registered read. Read-during-write to the same address returns old data; only possible across back-to-back commands.

Optional Feature:
BACKPRESSURE_EN: when defined, inserts deterministic stalls.
- WR_BURST and IDLE write: waitrequest=1 for one cycle before every beat whose index[1:0]==3. That beat is held until waitrequest drops.
- RD_BURST: one readdatavalid gap after every 4th delivered beat.
- Total read beats are unchanged.
When undefined: no inserted stalls; timing exactly as above.

Test Plan:
- Reset, then single write addr 0x000005, bc=1, data 0xA5A5; read bc=1 -> readdatavalid exactly READ_LATENCY=2 cycles after acceptance, readdata=0xA5A5, beats_wr=1, beats_rd=1, err=0.
- 256-beat write from 0x000000 with data 0x0000..0x00FF, then 256-beat read -> 256 contiguous readdatavalid cycles, data 0x0000..0x00FF in order, beats_wr=beats_rd=256.
- Wrap: 8-beat write at 0x0003FC (MEM_AW=10) with data 1..8 -> read of 4 beats at 0x000000 returns 5,6,7,8.
- byteenable=2'b01 write of 0xFFFF over stored 0x1234 -> read returns 0x12FF.
- bc=0 command, and read+write together during WR_BURST -> err=1 and stays 1 until reset; single beat processed.
- BACKPRESSURE_EN defined, 8-beat write -> waitrequest pulses before beats 3 and 7, all 8 stored. 8-beat read -> gap after beat 4, 8 valid beats. Reset asserted mid-read -> readdatavalid=0 next cycle, busy=0.
